// File: rtl/bird_motion_ctrl.sv
// bird_motion_ctrl: per-frame sequencer for the bird sprite.
// Game states are IDLE, PLAY, DEAD and OVER. Position and velocity are updated on
// frame_tick. pipe_hit takes effect in any cycle.
// Ports:
//   clk, rst_n          clock and asynchronous active-low reset
//   frame_tick          one-cycle pulse per frame
//   flap_key            flap key level; a rising edge queues one flap
//   pipe_hit            the bird overlaps a pipe
//   color_sel_in        skin choice, latched at game start
//   bird_height         sprite top-edge row
//   bird_angle          sprite angle index
//   bird_color_select   latched skin
//   bird_valid          sprite enable
//   game_active         high in PLAY
//   bird_dead           high in DEAD and OVER
module bird_motion_ctrl #(
  parameter logic        [8:0] START_HEIGHT = 9'd200,
  parameter logic        [8:0] CEILING      = 9'd0,
  parameter logic        [8:0] GROUND       = 9'd448,
  parameter logic signed [7:0] GRAVITY      = 8'sd2,
  parameter logic signed [7:0] FLAP_VEL     = -8'sd24,
  parameter logic signed [7:0] VMAX         = 8'sd32,
  parameter logic        [3:0] IDLE_ANGLE   = 4'd5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       flap_key,
  input  logic       pipe_hit,
  input  logic [1:0] color_sel_in,
  output logic [8:0] bird_height,
  output logic [3:0] bird_angle,
  output logic [1:0] bird_color_select,
  output logic       bird_valid,
  output logic       game_active,
  output logic       bird_dead
);

  typedef enum logic [1:0] {IDLE, PLAY, DEAD, OVER} state_t;

  localparam logic        [10:0] START_Q  = {START_HEIGHT, 2'b00};
  localparam logic signed [11:0] CEIL_Q   = signed'({1'b0, CEILING, 2'b00});
  localparam logic signed [11:0] GROUND_Q = signed'({1'b0, GROUND, 2'b00});
  localparam logic signed [11:0] LAUNCH_S = signed'({1'b0, START_Q}) + 12'(FLAP_VEL);
  localparam logic        [10:0] LAUNCH_Q = LAUNCH_S[10:0];

  state_t            state, state_n;
  logic       [10:0] pos, pos_n;
  logic signed [7:0] vel, vel_n;
  logic        [2:0] bob, bob_n;
  logic              bob_down, bob_down_n;
  logic        [1:0] bob_div, bob_div_n;
  logic              flap_prev;
  logic              flap_pending, flap_pending_n;
  logic        [1:0] color, color_n;

  logic              flap_edge;
  logic signed [8:0] vel_sum;
  logic signed [7:0] vel_grav;
  logic signed [7:0] vel_step;
  logic signed [11:0] pos_sum;
  logic signed [8:0] ang_diff;
  logic        [8:0] ang_u;
  logic        [8:0] ang_shift;
  logic        [3:0] angle_motion;

  assign flap_edge = flap_key & ~flap_prev;

  // Shared physics step; PLAY substitutes the flap velocity when one is queued.
  always_comb begin
    vel_sum  = 9'(vel) + 9'(GRAVITY);
    vel_grav = (vel_sum > 9'(VMAX)) ? VMAX : vel_sum[7:0];
    vel_step = (state == PLAY && flap_pending) ? FLAP_VEL : vel_grav;
    pos_sum  = signed'({1'b0, pos}) + 12'(vel_step);
  end

  always_comb begin
    ang_diff     = 9'(vel) - 9'(FLAP_VEL);
    ang_u        = ang_diff;
    ang_shift    = ang_u >> 2;
    angle_motion = (ang_shift > 9'd10) ? 4'd10 : ang_shift[3:0];
  end

  always_comb begin
    state_n        = state;
    pos_n          = pos;
    vel_n          = vel;
    bob_n          = bob;
    bob_down_n     = bob_down;
    bob_div_n      = bob_div;
    color_n        = color;
    flap_pending_n = flap_pending | flap_edge;
    case (state)
      IDLE: begin
        if (frame_tick) begin
          flap_pending_n = flap_edge;
          if (flap_pending) begin
            color_n = color_sel_in;
            vel_n   = FLAP_VEL;
            pos_n   = LAUNCH_Q;
            state_n = PLAY;
          end else begin
            bob_div_n = bob_div + 2'd1;
            if (bob_div == 2'd3) begin
              if (!bob_down) begin
                if (bob == 3'd7) begin
                  bob_n      = 3'd6;
                  bob_down_n = 1'b1;
                end else begin
                  bob_n = bob + 3'd1;
                end
              end else begin
                if (bob == 3'd0) begin
                  bob_n      = 3'd1;
                  bob_down_n = 1'b0;
                end else begin
                  bob_n = bob - 3'd1;
                end
              end
            end
          end
        end
      end
      PLAY: begin
        if (pipe_hit) begin
          state_n        = DEAD;
          vel_n          = '0;
          flap_pending_n = 1'b0;
        end else if (frame_tick) begin
          flap_pending_n = flap_edge;
          vel_n          = vel_step;
          if (pos_sum <= CEIL_Q) begin
            pos_n = CEIL_Q[10:0];
            vel_n = '0;
          end else if (pos_sum >= GROUND_Q) begin
            pos_n   = GROUND_Q[10:0];
            vel_n   = '0;
            state_n = OVER;
          end else begin
            pos_n = pos_sum[10:0];
          end
        end
      end
      DEAD: begin
        flap_pending_n = 1'b0;
        if (frame_tick) begin
          vel_n = vel_step;
          if (pos_sum >= GROUND_Q) begin
            pos_n   = GROUND_Q[10:0];
            vel_n   = '0;
            state_n = OVER;
          end else begin
            pos_n = pos_sum[10:0];
          end
        end
      end
      OVER: begin
        flap_pending_n = 1'b0;
        pos_n          = GROUND_Q[10:0];
        if (flap_edge) begin
          state_n    = IDLE;
          pos_n      = START_Q;
          vel_n      = '0;
          bob_n      = '0;
          bob_down_n = 1'b0;
          bob_div_n  = '0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      pos          <= START_Q;
      vel          <= '0;
      bob          <= '0;
      bob_down     <= 1'b0;
      bob_div      <= '0;
      flap_prev    <= 1'b0;
      flap_pending <= 1'b0;
      color        <= '0;
    end else begin
      state        <= state_n;
      pos          <= pos_n;
      vel          <= vel_n;
      bob          <= bob_n;
      bob_down     <= bob_down_n;
      bob_div      <= bob_div_n;
      flap_prev    <= flap_key;
      flap_pending <= flap_pending_n;
      color        <= color_n;
    end
  end

  always_comb begin
    bird_height = pos[10:2];
    bird_angle  = angle_motion;
    case (state)
      IDLE: begin
        bird_height = START_HEIGHT + 9'(bob);
        bird_angle  = IDLE_ANGLE;
      end
      OVER:    bird_angle = 4'd10;
      default: bird_angle = angle_motion;
    endcase
  end

  assign bird_color_select = color;
  assign bird_valid        = 1'b1;
  assign game_active       = (state == PLAY);
  assign bird_dead         = (state == DEAD) || (state == OVER);

endmodule

// File: tb/tb_bird_motion_ctrl.sv
module tb_bird_motion_ctrl;

  logic       clk;
  logic       rst_n;
  logic       frame_tick;
  logic       flap_key;
  logic       pipe_hit;
  logic [1:0] color_sel_in;
  logic [8:0] bird_height;
  logic [3:0] bird_angle;
  logic [1:0] bird_color_select;
  logic       bird_valid;
  logic       game_active;
  logic       bird_dead;

  int errors = 0;
  int checks = 0;

  bird_motion_ctrl dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .frame_tick        (frame_tick),
    .flap_key          (flap_key),
    .pipe_hit          (pipe_hit),
    .color_sel_in      (color_sel_in),
    .bird_height       (bird_height),
    .bird_angle        (bird_angle),
    .bird_color_select (bird_color_select),
    .bird_valid        (bird_valid),
    .game_active       (game_active),
    .bird_dead         (bird_dead)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1 frame_tick = 1'b1;
    @(posedge clk);
    #1 frame_tick = 1'b0;
  endtask

  task automatic press();
    @(posedge clk);
    #1 flap_key = 1'b1;
    @(posedge clk);
    #1 flap_key = 1'b0;
  endtask

  task automatic flap_tick();
    press();
    tick();
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_height"}, 32'(bird_height), 32'd200);
    check({tag, "_angle"},  32'(bird_angle),  32'd5);
    check({tag, "_valid"},  32'(bird_valid),  32'd1);
    check({tag, "_active"}, 32'(game_active), 32'd0);
    check({tag, "_dead"},   32'(bird_dead),   32'd0);
    check({tag, "_color"},  32'(bird_color_select), 32'd0);
  endtask

  initial begin
    clk = 1'b0; rst_n = 1'b0; frame_tick = 1'b0; flap_key = 1'b0;
    pipe_hit = 1'b0; color_sel_in = 2'd0;

    #3;
    check_reset_state("rst");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // idle bob: one step per 4 ticks, triangle peak at 7
    repeat (3) tick();
    check("bob_t3", 32'(bird_height), 32'd200);
    tick();
    check("bob_t4", 32'(bird_height), 32'd201);
    repeat (24) tick();
    check("bob_t28", 32'(bird_height), 32'd207);
    repeat (4) tick();
    check("bob_t32", 32'(bird_height), 32'd206);

    // launch
    color_sel_in = 2'd2;
    flap_tick();
    color_sel_in = 2'd0;
    check("start_height", 32'(bird_height), 32'd194);
    check("start_color",  32'(bird_color_select), 32'd2);
    check("start_angle",  32'(bird_angle), 32'd0);
    check("start_active", 32'(game_active), 32'd1);
    check("start_dead",   32'(bird_dead), 32'd0);
    tick();
    check("play_t2_height", 32'(bird_height), 32'd188);
    check("play_t2_angle",  32'(bird_angle), 32'd0);
    tick();
    check("play_t3_height", 32'(bird_height), 32'd183);
    check("play_t3_angle",  32'(bird_angle), 32'd1);

    // held key gives a single flap
    @(posedge clk);
    #1 flap_key = 1'b1;
    repeat (10) tick();
    flap_key = 1'b0;
    check("held_height", 32'(bird_height), 32'd146);
    check("held_angle",  32'(bird_angle), 32'd4);

    // free fall to terminal velocity
    repeat (19) tick();
    check("fall19_height", 32'(bird_height), 32'd212);
    check("fall19_angle",  32'(bird_angle), 32'd10);
    tick();
    check("fall20_height", 32'(bird_height), 32'd220);

    // flap every tick up to the ceiling
    repeat (36) flap_tick();
    check("ceil36_height", 32'(bird_height), 32'd4);
    check("ceil36_angle",  32'(bird_angle), 32'd0);
    flap_tick();
    check("ceil37_height", 32'(bird_height), 32'd0);
    check("ceil37_angle",  32'(bird_angle), 32'd6);
    tick();
    check("ceil_grav_height", 32'(bird_height), 32'd0);
    check("ceil_grav_angle",  32'(bird_angle), 32'd6);
    flap_tick();
    check("ceil_nowrap_height", 32'(bird_height), 32'd0);
    check("ceil_nowrap_active", 32'(game_active), 32'd1);

    // pipe hit together with tick and pending flap
    press();
    @(posedge clk);
    #1 frame_tick = 1'b1; pipe_hit = 1'b1;
    @(posedge clk);
    #1 frame_tick = 1'b0; pipe_hit = 1'b0;
    check("hit_dead",   32'(bird_dead), 32'd1);
    check("hit_active", 32'(game_active), 32'd0);
    check("hit_height", 32'(bird_height), 32'd0);
    check("hit_angle",  32'(bird_angle), 32'd6);

    // dead: flaps ignored, gravity only
    repeat (5) flap_tick();
    check("dead5_height", 32'(bird_height), 32'd7);
    check("dead5_angle",  32'(bird_angle), 32'd8);
    repeat (58) tick();
    check("dead63_height", 32'(bird_height), 32'd444);
    check("dead63_dead",   32'(bird_dead), 32'd1);
    tick();
    check("over_height", 32'(bird_height), 32'd448);
    check("over_angle",  32'(bird_angle), 32'd10);
    check("over_dead",   32'(bird_dead), 32'd1);
    check("over_active", 32'(game_active), 32'd0);
    repeat (3) tick();
    check("over_hold_height", 32'(bird_height), 32'd448);

    // restart
    press();
    check("restart_height", 32'(bird_height), 32'd200);
    check("restart_angle",  32'(bird_angle), 32'd5);
    check("restart_dead",   32'(bird_dead), 32'd0);
    check("restart_active", 32'(game_active), 32'd0);

    // land without flapping
    color_sel_in = 2'd1;
    flap_tick();
    check("land_start_color",  32'(bird_color_select), 32'd1);
    check("land_start_height", 32'(bird_height), 32'd194);
    repeat (55) tick();
    check("land55_height", 32'(bird_height), 32'd445);
    check("land55_active", 32'(game_active), 32'd1);
    tick();
    check("land56_height", 32'(bird_height), 32'd448);
    check("land56_dead",   32'(bird_dead), 32'd1);
    check("land56_active", 32'(game_active), 32'd0);
    check("land56_angle",  32'(bird_angle), 32'd10);

    // asynchronous reset in the middle of play
    press();
    color_sel_in = 2'd3;
    flap_tick();
    repeat (5) tick();
    check("pre_rst_active", 32'(game_active), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_reset_state("mid_rst");
    #5 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
